// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers and InvMixColumns coefficient table
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1b;

    localparam logic [7:0] INV_MC [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [7:0] gf_mul_coef(input logic [7:0] c, input logic [7:0] a);
        case (c)
            8'h09:   return gf_mul09(a);
            8'h0b:   return gf_mul0b(a);
            8'h0d:   return gf_mul0d(a);
            8'h0e:   return gf_mul0e(a);
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/inv_mixcolumn_8_if.sv
// rtl/inv_mixcolumn_8_if.sv - byte-in / byte-out stream pair of the InvMixColumns engine
interface inv_mixcolumn_8_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/inv_mc_coef.sv
// rtl/inv_mc_coef.sv - products of one input byte with column k of the inverse matrix
module inv_mc_coef
    import aes_pkg::*;
(
    input  logic [7:0]      din,
    input  logic [1:0]      col,
    output logic [3:0][7:0] prod
);

    always_comb begin
        prod = '0;
        for (int j = 0; j < 4; j++) begin
            prod[j] = gf_mul_coef(INV_MC[j][col], din);
        end
    end

endmodule

// File: rtl/inv_mixcolumn_8.sv
// rtl/inv_mixcolumn_8.sv - byte-serial AES InvMixColumns; INV_MIXCOL_BYPASS_EN adds a pass-through port
module inv_mixcolumn_8
    import aes_pkg::*;
#(
    parameter int NCOL = 0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef INV_MIXCOL_BYPASS_EN
    input  logic bypass,
`endif
    inv_mixcolumn_8_if.slave bus
);

    if (NCOL < 0) begin : g_ncol_check
        $error("NCOL must be non-negative");
    end

    logic [1:0]      in_ph_q, in_ph_d;
    logic [1:0]      out_ph_q, out_ph_d;
    logic            obuf_full_q, obuf_full_d;
    logic [3:0][7:0] acc_q, acc_d;
    logic [3:0][7:0] obuf_q, obuf_d;
    logic [3:0][7:0] prod;
    logic [3:0][7:0] term;
    logic            in_fire, out_fire, out_done;

    inv_mc_coef u_coef (
        .din  (bus.in_data),
        .col  (in_ph_q),
        .prod (prod)
    );

    assign out_fire = obuf_full_q & bus.out_ready;
    assign out_done = out_fire & (out_ph_q == 2'd3);
    // The last input byte may land in the same cycle the final output byte leaves.
    assign bus.in_ready  = (in_ph_q != 2'd3) | ~obuf_full_q | out_done;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign bus.out_data  = obuf_q[out_ph_q];
    assign bus.out_valid = obuf_full_q;
    assign bus.out_last  = (out_ph_q == 2'd3);

`ifdef INV_MIXCOL_BYPASS_EN
    logic bypass_q, bypass_d, byp_cur;

    assign byp_cur  = (in_ph_q == 2'd0) ? bypass : bypass_q;
    assign bypass_d = (in_fire && in_ph_q == 2'd0) ? bypass : bypass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bypass_q <= 1'b0;
        else        bypass_q <= bypass_d;
    end
`endif

    always_comb begin
        term = prod;
`ifdef INV_MIXCOL_BYPASS_EN
        if (byp_cur) begin
            term          = '0;
            term[in_ph_q] = bus.in_data;
        end
`endif
    end

    always_comb begin
        in_ph_d     = in_ph_q;
        out_ph_d    = out_ph_q;
        obuf_full_d = obuf_full_q;
        acc_d       = acc_q;
        obuf_d      = obuf_q;

        if (out_fire) begin
            out_ph_d = out_ph_q + 2'd1;
            if (out_done) obuf_full_d = 1'b0;
        end

        if (in_fire) begin
            in_ph_d = in_ph_q + 2'd1;
            for (int j = 0; j < 4; j++) begin
                acc_d[j] = ((in_ph_q == 2'd0) ? 8'h00 : acc_q[j]) ^ term[j];
            end
            if (in_ph_q == 2'd3) begin
                obuf_d      = acc_d;
                obuf_full_d = 1'b1;
                out_ph_d    = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ph_q     <= 2'd0;
            out_ph_q    <= 2'd0;
            obuf_full_q <= 1'b0;
            acc_q       <= '0;
            obuf_q      <= '0;
        end else begin
            in_ph_q     <= in_ph_d;
            out_ph_q    <= out_ph_d;
            obuf_full_q <= obuf_full_d;
            acc_q       <= acc_d;
            obuf_q      <= obuf_d;
        end
    end

endmodule

// File: tb/tb_inv_mixcolumn_8.sv
// tb/tb_inv_mixcolumn_8.sv - directed-vector bench for inv_mixcolumn_8 (INV_MIXCOL_BYPASS_EN aware)
module tb_inv_mixcolumn_8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inv_mixcolumn_8_if bus ();
`ifdef INV_MIXCOL_BYPASS_EN
    logic bypass;
`endif

    inv_mixcolumn_8 #(.NCOL(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef INV_MIXCOL_BYPASS_EN
        .bypass (bypass),
`endif
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    bit         hold_out   = 1'b0;
    int         gap_pct    = 0;
    bit         chk_bubble = 1'b0;
    bit         chk_lat    = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_col(input logic [7:0] a0, a1, a2, a3);
        in_q.push_back(a0); in_q.push_back(a1); in_q.push_back(a2); in_q.push_back(a3);
    endtask

    task automatic expect_col(input logic [7:0] b0, b1, b2, b3);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
        exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0);
        exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b1);
    endtask

    task automatic run(input int n_cycles, input bit until_done);
        bit started     = 1'b0;
        bit lat_pending = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            if (until_done && in_q.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
            bus.out_ready = !hold_out;
            bus.in_valid  = (in_q.size() != 0) && ($urandom_range(99) >= gap_pct);
            bus.in_data   = bus.in_valid ? in_q[0] : 8'h00;
            #1;
            if (lat_pending) begin
                check_value("latency", 32'(bus.out_valid), 1);
                lat_pending = 1'b0;
            end
            if (chk_bubble && started && exp_q.size() != 0)
                check_value("no_bubble", 32'(bus.out_valid), 1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("spurious_out", 32'(bus.out_valid), 0);
                end else begin
                    check_value("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                    check_value("out_last", 32'(bus.out_last), 32'(exp_last_q[0]));
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                    started = 1'b1;
                end
            end
            if (bus.in_valid && !bus.in_ready)
                check_value("stall_phase", 32'(in_q.size() % 4), 1);
            if (bus.in_valid && bus.in_ready) begin
                if (chk_lat && in_q.size() == 1) begin
                    check_value("pre_latency", 32'(bus.out_valid), 0);
                    lat_pending = 1'b1;
                end
                void'(in_q.pop_front());
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (until_done) begin
            check_value("timeout_in", 32'(in_q.size()), 0);
            check_value("timeout_out", 32'(exp_q.size()), 0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef INV_MIXCOL_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_out_valid", 32'(bus.out_valid), 0);
        check_value("rst_out_data", 32'(bus.out_data), 0);
        check_value("rst_out_last", 32'(bus.out_last), 0);
        check_value("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // single column, latency
        chk_lat = 1'b1;
        push_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        expect_col(8'hdb, 8'h13, 8'h53, 8'h45);
        run(100, 1'b1);
        chk_lat = 1'b0;

        // back-to-back, no bubble
        chk_bubble = 1'b1;
        push_col(8'h9f, 8'hdc, 8'h58, 8'h9d);
        push_col(8'h01, 8'h01, 8'h01, 8'h01);
        expect_col(8'hf2, 8'h0a, 8'h22, 8'h5c);
        expect_col(8'h01, 8'h01, 8'h01, 8'h01);
        run(100, 1'b1);
        chk_bubble = 1'b0;

        // output backpressure across a second column
        hold_out = 1'b1;
        push_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        push_col(8'h9f, 8'hdc, 8'h58, 8'h9d);
        expect_col(8'hdb, 8'h13, 8'h53, 8'h45);
        expect_col(8'hf2, 8'h0a, 8'h22, 8'h5c);
        run(12, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = in_q[0];
        bus.out_ready = 1'b0;
        #1;
        check_value("bp_remaining", 32'(in_q.size()), 1);
        check_value("bp_in_ready", 32'(bus.in_ready), 0);
        check_value("bp_out_valid", 32'(bus.out_valid), 1);
        check_value("bp_out_data", 32'(bus.out_data), 32'h db);
        hold_out = 1'b0;
        run(100, 1'b1);

        // input gaps inside a column
        gap_pct = 40;
        push_col(8'hc6, 8'hc6, 8'hc6, 8'hc6);
        expect_col(8'hc6, 8'hc6, 8'hc6, 8'hc6);
        run(200, 1'b1);
        gap_pct = 0;

        // reset mid-column discards the partial column
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check_value("mid_rst_out_data", 32'(bus.out_data), 0);
        check_value("mid_rst_out_last", 32'(bus.out_last), 0);
        check_value("mid_rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        push_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        expect_col(8'hdb, 8'h13, 8'h53, 8'h45);
        run(100, 1'b1);

`ifdef INV_MIXCOL_BYPASS_EN
        bypass = 1'b1;
        push_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        expect_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        run(100, 1'b1);
        bypass = 1'b0;
        push_col(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        expect_col(8'hdb, 8'h13, 8'h53, 8'h45);
        run(100, 1'b1);
`endif

        @(negedge clk);
        #1;
        check_value("idle_out_valid", 32'(bus.out_valid), 0);
        check_value("idle_in_ready", 32'(bus.in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
